// File: rtl/eq_pkg.sv
// Shared equalizer definitions: band/tap geometry, the Q1.15 band filter table
// used by both the equalizer and the level meter, and the meter FSM states.
package eq_pkg;

  localparam int NUM_BANDS = 8;
  localparam int NUM_TAPS  = 15;
  localparam int COEF_W    = 16;
  localparam int ACC_W     = 36;

  typedef logic signed [COEF_W-1:0] coef_tbl_t [NUM_BANDS][NUM_TAPS];

  // Row = band (0 lowest), column = tap (0 multiplies the newest sample).
  localparam coef_tbl_t BAND_COEF = '{
    '{16'sd1200, 16'sd1500, 16'sd1800, 16'sd2100, 16'sd2400, 16'sd2500, 16'sd2729, 16'sd4300,
      16'sd2729, 16'sd2500, 16'sd2400, 16'sd2100, 16'sd1800, 16'sd1500, 16'sd1200},
    '{-16'sd200, -16'sd400, -16'sd300, 16'sd300, 16'sd1500, 16'sd3000, 16'sd4300, 16'sd5000,
      16'sd4300, 16'sd3000, 16'sd1500, 16'sd300, -16'sd300, -16'sd400, -16'sd200},
    '{16'sd200, 16'sd300, -16'sd200, -16'sd1500, -16'sd3000, -16'sd2000, 16'sd2500, 16'sd6000,
      16'sd2500, -16'sd2000, -16'sd3000, -16'sd1500, -16'sd200, 16'sd300, 16'sd200},
    '{-16'sd300, 16'sd500, 16'sd1500, 16'sd0, -16'sd4000, -16'sd3000, 16'sd4000, 16'sd7500,
      16'sd4000, -16'sd3000, -16'sd4000, 16'sd0, 16'sd1500, 16'sd500, -16'sd300},
    '{16'sd400, -16'sd800, -16'sd1500, 16'sd2500, 16'sd2000, -16'sd5500, -16'sd3000, 16'sd8500,
      -16'sd3000, -16'sd5500, 16'sd2000, 16'sd2500, -16'sd1500, -16'sd800, 16'sd400},
    '{-16'sd500, 16'sd1200, -16'sd1000, -16'sd2500, 16'sd5500, -16'sd1500, -16'sd7000, 16'sd10060,
      -16'sd7000, -16'sd1500, 16'sd5500, -16'sd2500, -16'sd1000, 16'sd1200, -16'sd500},
    '{16'sd300, -16'sd900, 16'sd2000, -16'sd3500, 16'sd5000, -16'sd6500, 16'sd8000, 16'sd14702,
      16'sd8000, -16'sd6500, 16'sd5000, -16'sd3500, 16'sd2000, -16'sd900, 16'sd300},
    '{16'sd700, -16'sd1200, 16'sd1900, -16'sd2100, 16'sd2700, -16'sd2352, 16'sd2873, -16'sd5108,
      16'sd2873, -16'sd2352, 16'sd2700, -16'sd2100, 16'sd1900, -16'sd1200, 16'sd700}
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_UPD  = 2'd2
  } state_e;

endpackage

// File: rtl/band_mac.sv
// Signed multiply-accumulate shared by all bands; clr restarts the sum with
// the current product instead of adding to the previous band's result.
module band_mac
  import eq_pkg::*;
#(
  parameter int A_W   = COEF_W,
  parameter int B_W   = 16,
  parameter int SUM_W = ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [SUM_W-1:0] acc
);

  logic signed [A_W+B_W-1:0] prod;
  logic signed [SUM_W-1:0]   acc_d, acc_q;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (en) begin
      acc_d = (clr ? '0 : acc_q) + SUM_W'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/band_level_meter.sv
// Eight-band peak level meter: one MAC walks 8 bands x 15 taps per sample and
// publishes the per-band peak magnitudes every WIN_LEN samples.
module band_level_meter
  import eq_pkg::*;
#(
  parameter int WIN_LEN = 1024,
  parameter int DATA_W  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [DATA_W-1:0]            in_sample,
  output logic                                lvl_valid,
  output logic [NUM_BANDS-1:0][DATA_W-1:0]    lvl,
  output logic                                busy
);

  localparam int CNT_W = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN - 1);
  localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'((longint'(1) << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] R_MIN = ACC_W'(-(longint'(1) << (DATA_W - 1)));
  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] M_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  state_e                               state_d, state_q;
  logic [2:0]                           band_d, band_q;
  logic [3:0]                           tap_d, tap_q;
  logic [CNT_W-1:0]                     win_d, win_q;
  logic [NUM_TAPS-1:0][DATA_W-1:0]      dly_d, dly_q;
  logic [NUM_BANDS-1:0][DATA_W-1:0]     peak_d, peak_q;
  logic [NUM_BANDS-1:0][DATA_W-1:0]     lvl_d, lvl_q;
  logic                                 lvl_valid_d, lvl_valid_q;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  r_full;
  logic signed [DATA_W-1:0] sat;
  logic [DATA_W-1:0]        mag;
  logic [DATA_W-1:0]        new_peak;

  band_mac #(.A_W(COEF_W), .B_W(DATA_W), .SUM_W(ACC_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .en  (state_q == ST_MAC),
    .clr (tap_q == 4'd0),
    .a   (BAND_COEF[band_q][tap_q]),
    .b   (dly_q[tap_q]),
    .acc (acc)
  );

  // Scale Q1.15 products back to sample units, then fold to a magnitude that
  // always fits the unsigned level width.
  always_comb begin
    r_full = acc >>> 15;
    if (r_full > R_MAX)      sat = R_MAX[DATA_W-1:0];
    else if (r_full < R_MIN) sat = R_MIN[DATA_W-1:0];
    else                     sat = r_full[DATA_W-1:0];
    if (sat == S_MIN)        mag = M_MAX;
    else if (sat[DATA_W-1])  mag = unsigned'(-sat);
    else                     mag = unsigned'(sat);
    new_peak = (mag > peak_q[band_q]) ? mag : peak_q[band_q];
  end

  always_comb begin
    state_d     = state_q;
    band_d      = band_q;
    tap_d       = tap_q;
    win_d       = win_q;
    dly_d       = dly_q;
    peak_d      = peak_q;
    lvl_d       = lvl_q;
    lvl_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dly_d   = {dly_q[NUM_TAPS-2:0], in_sample};
          band_d  = 3'd0;
          tap_d   = 4'd0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        if (tap_q == 4'(NUM_TAPS - 1)) state_d = ST_UPD;
        else                           tap_d   = tap_q + 4'd1;
      end
      ST_UPD: begin
        peak_d[band_q] = new_peak;
        tap_d          = 4'd0;
        if (band_q == 3'(NUM_BANDS - 1)) begin
          state_d = ST_IDLE;
          // Last band of the last sample: publish including this result.
          if (win_q == WIN_LAST) begin
            lvl_d                = peak_q;
            lvl_d[NUM_BANDS-1]   = new_peak;
            lvl_valid_d          = 1'b1;
            peak_d               = '0;
            win_d                = '0;
          end else begin
            win_d = win_q + 1'b1;
          end
        end else begin
          band_d  = band_q + 3'd1;
          state_d = ST_MAC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      band_q      <= '0;
      tap_q       <= '0;
      win_q       <= '0;
      dly_q       <= '0;
      peak_q      <= '0;
      lvl_q       <= '0;
      lvl_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      band_q      <= band_d;
      tap_q       <= tap_d;
      win_q       <= win_d;
      dly_q       <= dly_d;
      peak_q      <= peak_d;
      lvl_q       <= lvl_d;
      lvl_valid_q <= lvl_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign lvl       = lvl_q;
  assign lvl_valid = lvl_valid_q;

endmodule

// File: tb/tb_band_level_meter.sv
// Bench for band_level_meter: sample-level reference model checked every
// cycle, scoreboard on published windows, literal checks on known patterns.
module tb_band_level_meter;
  import eq_pkg::*;

  localparam int WIN  = 16;
  localparam int DW   = 16;
  localparam int LW   = NUM_BANDS * DW;
  localparam int PROC = NUM_BANDS * (NUM_TAPS + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [DW-1:0] in_sample = '0;
  logic in_ready, lvl_valid, busy;
  logic [NUM_BANDS-1:0][DW-1:0] lvl;

  always #5 clk = ~clk;

  band_level_meter #(.WIN_LEN(WIN), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sample (in_sample),
    .lvl_valid (lvl_valid),
    .lvl       (lvl),
    .busy      (busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  longint hist[NUM_TAPS];
  int peak_m[NUM_BANDS];
  int win_m;
  int busy_left;
  bit pub_pending;
  logic lvl_valid_m;
  logic [NUM_BANDS-1:0][DW-1:0] lvl_m, pub_m;
  logic [LW-1:0] exp_q[$];

  function automatic int band_level(input int b);
    longint acc = 0;
    longint r;
    for (int k = 0; k < NUM_TAPS; k++) acc += longint'(BAND_COEF[b][k]) * hist[k];
    r = acc >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (r < 0) r = -r;
    if (r > 32767) r = 32767;
    return int'(r);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS; k++) hist[k] = 0;
      for (int b = 0; b < NUM_BANDS; b++) peak_m[b] = 0;
      win_m = 0; busy_left = 0; pub_pending = 0;
      lvl_valid_m = 1'b0; lvl_m = '0; pub_m = '0;
    end else begin
      lvl_valid_m = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0 && pub_pending) begin
          lvl_m = pub_m; lvl_valid_m = 1'b1; pub_pending = 0;
          exp_q.push_back(pub_m);
        end
      end else if (in_valid) begin
        for (int k = NUM_TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'(in_sample);
        for (int b = 0; b < NUM_BANDS; b++) begin
          int m;
          m = band_level(b);
          if (m > peak_m[b]) peak_m[b] = m;
        end
        win_m++;
        if (win_m == WIN) begin
          for (int b = 0; b < NUM_BANDS; b++) begin
            pub_m[b] = peak_m[b][DW-1:0];
            peak_m[b] = 0;
          end
          pub_pending = 1; win_m = 0;
        end
        busy_left = PROC;
      end
    end
  end

  // ---------------- compare + scoreboard ----------------
  int pulse_cnt = 0;
  logic [NUM_BANDS-1:0][DW-1:0] last_lvl = '0;
  logic [LW-1:0] pub_log[$];

  always @(posedge clk) begin
    #2;
    chk("in_ready", in_ready, (!rst && busy_left == 0));
    chk("busy", busy, busy_left != 0);
    chk("lvl_valid", lvl_valid, lvl_valid_m);
    for (int b = 0; b < NUM_BANDS; b++) chk($sformatf("lvl%0d", b), lvl[b], lvl_m[b]);
    if (lvl_valid) begin
      pulse_cnt++;
      last_lvl = lvl;
      pub_log.push_back(lvl);
      if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
      else chk("sb_lvl", lvl, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  logic signed [DW-1:0] samp_tbl[32];
  int acc_cyc[32];
  logic [LW-1:0] bt_res[2];

  task automatic send(input logic signed [DW-1:0] s);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_sample = s;
    #1;
    while (!in_ready && n < 300) begin
      @(negedge clk); #1; n++;
    end
    chk("send_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic stream(input bit stall);
    int idx = 0;
    int n = 0;
    while (idx < 32 && n < 8000) begin
      @(negedge clk);
      in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_sample = samp_tbl[idx];
      #1;
      if (in_valid && in_ready) begin
        acc_cyc[idx] = cyc; idx++;
      end
      n++;
    end
    chk("stream_count", idx, 32);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int p0;
    for (int i = 0; i < 32; i++) begin
      if (i < 16) samp_tbl[i] = (i % 3 == 0) ? 16'sd30000 : (i % 3 == 1) ? -16'sd25000 : 16'sd12000;
      else        samp_tbl[i] = (i % 2 == 1) ? 16'sd1000 : -16'sd2000;
    end

    repeat (5) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lvl_valid", lvl_valid, 0);
    chk("rst_lvl", lvl, 0);
    rst = 1'b0;
    #1 chk("rel_in_ready", in_ready, 1);

    // Impulse of 0.5 full scale: level = |floor(coef/2)| of each band's largest tap.
    p0 = pulse_cnt;
    send(16'sd16384);
    for (int i = 0; i < 15; i++) send(16'sd0);
    repeat (140) @(negedge clk);
    chk("imp_pulses", pulse_cnt - p0, 1);
    chk("imp_lvl0", last_lvl[0], 2150);
    chk("imp_lvl5", last_lvl[5], 5030);
    chk("imp_lvl6", last_lvl[6], 7351);
    chk("imp_lvl7", last_lvl[7], 2554);

    // Reset in the middle of the MAC sequence.
    send(16'sd20000);
    repeat (49) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_in_ready", in_ready, 1);
    chk("mid_rel_busy", busy, 0);
    chk("mid_rel_lvl", lvl, 0);
    p0 = pulse_cnt;
    repeat (200) @(negedge clk);
    chk("mid_no_pulse", pulse_cnt - p0, 0);

    // DC full scale.
    do_reset();
    for (int i = 0; i < 16; i++) send(16'sd32767);
    repeat (140) @(negedge clk);
    chk("dc_lvl0", last_lvl[0], 32757);
    chk("dc_lvl7", last_lvl[7], 2587);

    // Nyquist.
    do_reset();
    for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 16'sd32767 : -16'sd32768);
    repeat (140) @(negedge clk);
    chk("nyq_lvl7", last_lvl[7], 32758);

    // Back-to-back throughput.
    do_reset();
    pub_log.delete();
    stream(1'b0);
    repeat (140) @(negedge clk);
    chk("bt_pulses", pub_log.size(), 2);
    for (int i = 1; i < 32; i++) chk($sformatf("bt_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 129);
    for (int w = 0; w < 2; w++) bt_res[w] = (pub_log.size() > w) ? pub_log[w] : '0;

    // Random stalls must give identical windows.
    do_reset();
    pub_log.delete();
    stream(1'b1);
    repeat (140) @(negedge clk);
    chk("st_pulses", pub_log.size(), 2);
    for (int w = 0; w < 2; w++)
      chk($sformatf("st_win%0d", w), (pub_log.size() > w) ? pub_log[w] : '0, bt_res[w]);

    chk("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
